// File: rtl/dds_sine_gen_if.sv
// Control and sample bus of the DDS sine source: tuning/phase controls in,
// offset-binary samples with a valid flag out.
interface dds_sine_gen_if #(
  parameter int ACC_W  = 32,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
);
  logic              en;
  logic              clr;
  logic              fw_we;
  logic [ACC_W-1:0]  fw;
  logic [LUT_AW-1:0] phase_off;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;

  modport master (
    output en, clr, fw_we, fw, phase_off,
    input  dout, dout_valid
  );

  modport slave (
    input  en, clr, fw_we, fw, phase_off,
    output dout, dout_valid
  );
endinterface

// File: rtl/dds_sine_gen.sv
// Direct-digital-synthesis sine source: phase accumulator, quarter-wave ROM with
// symmetry folding and a 3-register pipeline (address, magnitude, output).
module dds_sine_gen #(
  parameter int               ACC_W    = 32,
  parameter int               LUT_AW   = 8,
  parameter int               OUT_W    = 8,
  parameter logic [ACC_W-1:0] FW_RESET = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  dds_sine_gen_if.slave  bus
);

  localparam int QAW = LUT_AW - 2;
  localparam int QN  = 1 << QAW;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  // Quarter-wave entry round(AMP*sin(pi*(2k+1)/2^LUT_AW)), evaluated with a
  // Q28 Taylor series so the table is built at elaboration without reals.
  function automatic logic [OUT_W-2:0] romEntry(input int k);
    longint piQ;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    longint val;
    piQ  = 64'sd843314857;
    amp  = (longint'(1) <<< (OUT_W - 1)) - 1;
    x    = (piQ * longint'(2 * k + 1)) >>> LUT_AW;
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    val = (amp * sum + (longint'(1) <<< 27)) >>> 28;
    return (OUT_W-1)'(val);
  endfunction

  logic [OUT_W-2:0] rom [QN];

  for (genvar k = 0; k < QN; k++) begin : gRom
    localparam logic [OUT_W-2:0] ENTRY = romEntry(k);
    assign rom[k] = ENTRY;
  end

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  fwReg_q;
  logic [LUT_AW-1:0] addr_q, addr_d;
  logic              v1_q;
  logic [OUT_W-2:0]  mag_q;
  logic              neg_q;
  logic              v2_q;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              valid_q;

  logic [1:0]        quad;
  logic [QAW-1:0]    idx;

  // Offset only touches the top LUT_AW bits, so adding it to the truncated
  // accumulator gives the same address as the full-width sum.
  always_comb begin
    acc_d  = acc_q + fwReg_q;
    addr_d = acc_q[ACC_W-1 -: LUT_AW] + bus.phase_off;
    quad   = addr_q[LUT_AW-1 -: 2];
    idx    = addr_q[QAW-1:0] ^ {QAW{quad[0]}};
    dout_d = neg_q ? {1'b0, ~mag_q} : {1'b1, mag_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      fwReg_q <= FW_RESET;
      addr_q  <= '0;
      v1_q    <= 1'b0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      v2_q    <= 1'b0;
      dout_q  <= MID;
      valid_q <= 1'b0;
    end else begin
      if (bus.fw_we) begin
        fwReg_q <= bus.fw;
      end
      if (bus.clr) begin
        acc_q   <= '0;
        v1_q    <= 1'b0;
        v2_q    <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        v1_q <= bus.en;
        if (bus.en) begin
          acc_q  <= acc_d;
          addr_q <= addr_d;
        end
        v2_q <= v1_q;
        if (v1_q) begin
          mag_q <= rom[idx];
          neg_q <= quad[1];
        end
        valid_q <= v2_q;
        if (v2_q) begin
          dout_q <= dout_d;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Self-checking bench for dds_sine_gen: hand-computed vector table plus a
// cycle model of the sine pipeline compared on every clock.
module tb_dds_sine_gen;
  localparam int ACC_W  = 32;
  localparam int LUT_AW = 8;
  localparam int OUT_W  = 8;
  localparam real PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n;

  dds_sine_gen_if #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) bus ();

  dds_sine_gen #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W), .FW_RESET('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mAcc, mFw;
  logic        d1V, d2V, oV;
  logic [7:0]  d1Val, d2Val, oVal;

  typedef struct {
    logic [7:0] phaseOff;
    logic [7:0] expDout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sineRef(input logic [7:0] a);
    real s;
    int  m;
    s = $sin(2.0 * PI * (real'(int'(a)) + 0.5) / 256.0);
    m = $rtoi(((s < 0.0) ? -s : s) * 127.0 + 0.5);
    return (s >= 0.0) ? 8'(128 + m) : 8'(127 - m);
  endfunction

  task automatic modelReset();
    mAcc  = '0;
    mFw   = '0;
    d1V   = 1'b0;
    d2V   = 1'b0;
    oV    = 1'b0;
    d1Val = 8'h80;
    d2Val = 8'h80;
    oVal  = 8'h80;
  endtask

  // Advance the reference by one clock using the inputs sampled at that edge.
  task automatic modelStep();
    if (bus.clr) begin
      mAcc = '0;
      d1V  = 1'b0;
      d2V  = 1'b0;
      oV   = 1'b0;
    end else begin
      oV = d2V;
      if (d2V) oVal = d2Val;
      d2V   = d1V;
      d2Val = d1Val;
      d1V   = bus.en;
      if (bus.en) begin
        d1Val = sineRef(8'(mAcc[31:24] + bus.phase_off));
        mAcc  = mAcc + mFw;
      end
    end
    if (bus.fw_we) mFw = bus.fw;
  endtask

  task automatic checkOutput();
    check("dout_valid", 32'(bus.dout_valid), 32'(oV));
    check("dout", 32'(bus.dout), 32'(oVal));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input logic fwWe,
                               input logic [31:0] fw, input logic [7:0] off);
    bus.en        = en;
    bus.clr       = clr;
    bus.fw_we     = fwWe;
    bus.fw        = fw;
    bus.phase_off = off;
    tick();
  endtask

  initial begin
    vecs[0] = '{8'd0,   8'h82};
    vecs[1] = '{8'd1,   8'h85};
    vecs[2] = '{8'd63,  8'hFF};
    vecs[3] = '{8'd64,  8'hFF};
    vecs[4] = '{8'd127, 8'h82};
    vecs[5] = '{8'd128, 8'h7D};
    vecs[6] = '{8'd191, 8'h00};
    vecs[7] = '{8'd255, 8'h7D};

    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.clr       = 1'b0;
    bus.fw_we     = 1'b0;
    bus.fw        = '0;
    bus.phase_off = '0;
    modelReset();
    #12;
    check("resetDout", 32'(bus.dout), 32'h80);
    check("resetValid", 32'(bus.dout_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    check("idleDout", 32'(bus.dout), 32'h80);

    // Table: fw_reg is still zero, so each single en pulse samples address phase_off.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, vecs[i].phaseOff);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, vecs[i].phaseOff);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, vecs[i].phaseOff);
      check("tableValid", 32'(bus.dout_valid), 32'h1);
      check("tableDout", 32'(bus.dout), 32'(vecs[i].expDout));
      applyStimulus(1'b0, 1'b0, 1'b0, '0, vecs[i].phaseOff);
      check("tableHold", 32'(bus.dout), 32'(vecs[i].expDout));
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0100_0000, '0);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      case (i)
        1:   check("stepLatency", 32'(bus.dout_valid), 32'h0);
        2:   check("stepFirst", 32'(bus.dout), 32'h82);
        3:   check("stepSecond", 32'(bus.dout), 32'h85);
        65:  check("stepAddr63", 32'(bus.dout), 32'hFF);
        66:  check("stepAddr64", 32'(bus.dout), 32'hFF);
        129: check("stepAddr127", 32'(bus.dout), 32'h82);
        130: check("stepAddr128", 32'(bus.dout), 32'h7D);
        193: check("stepAddr191", 32'(bus.dout), 32'h00);
        257: check("stepAddr255", 32'(bus.dout), 32'h7D);
        258: check("stepPeriod", 32'(bus.dout), 32'h82);
        default: ;
      endcase
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Park the accumulator just below 2^32, then return to the unit step.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0100_0000, '0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'd64);
    check("cosineStart", 32'(bus.dout), 32'hFF);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'd64);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
    check("clrFlush", 32'(bus.dout_valid), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    check("clrRestart", 32'(bus.dout), 32'h82);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0200_0000, '0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

    #2;
    rst_n = 1'b0;
    #1;
    check("asyncResetDout", 32'(bus.dout), 32'h80);
    check("asyncResetValid", 32'(bus.dout_valid), 32'h0);
    modelReset();
    bus.en    = 1'b0;
    bus.fw_we = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      if (i >= 2) check("fwAfterReset", 32'(bus.dout), 32'h82);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
Parametrised direct-digital-synthesis sine source. Successor to the fixed 256x8 full-wave sine table: it adds a phase accumulator, a runtime tuning word, a phase offset, a quarter-wave ROM with symmetry folding, and a registered 3-stage pipeline with a valid flag. It feeds the DAC/PWM output path.

Parameters:
ACC_W, 32, phase accumulator width (bits)
LUT_AW, 8, phase address width into the full wave; the ROM holds 2^(LUT_AW-2) entries
OUT_W, 8, output sample width, offset binary
FW_RESET, 0, tuning word value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  advance the accumulator and issue one sample this cycle
clr  in  1  synchronous phase clear; has priority over en
fw_we  in  1  load tuning word
fw  in  ACC_W  tuning word (phase increment per sample)
phase_off  in  LUT_AW  phase offset added to the accumulator top bits
dout  out  OUT_W  sine sample, offset binary
dout_valid  out  1  dout carries a new sample this cycle

Behaviour:
- Reset (async, rst_n=0):
  - acc=0, fw_reg=FW_RESET.
  - All pipeline valid bits 0, dout_valid=0.
  - dout=2^(OUT_W-1).
- Tuning word: on fw_we=1, fw_reg<=fw. The new word first applies to the increment on the following cycle. fw_we is independent of en and clr.
- Stage 0 (accumulator):
  - clr=1: acc<=0 and all valid bits clear.
  - else en=1: acc<=acc+fw_reg, modulo 2^ACC_W with silent wrap. The pre-increment acc enters stage 1 with v1<=1.
  - else: acc holds and v1<=0.
- Stage 1 (address): p1 <= (acc + {phase_off, ACC_W-LUT_AW zeros}) mod 2^ACC_W, keeping the top LUT_AW bits. Then:
  - q = p1[LUT_AW-1:LUT_AW-2]
  - idx = p1[LUT_AW-3:0]
  - If q[0]=1, idx is bitwise inverted (mirror).
- Stage 2 (ROM): mag <= QROM[idx]; q[1] is pipelined alongside; v2<=v1.
  - QROM[k] = round((2^(OUT_W-1)-1) * sin(2*pi*(k+0.5)/2^LUT_AW)), for k in 0..2^(LUT_AW-2)-1.
  - The half-sample offset makes the folding exactly symmetric.
  - Contents are generated at elaboration or from a generated include; the width rule is fixed.
- Stage 3 (output):
  - q[1]=0: dout <= 2^(OUT_W-1) + mag.
  - q[1]=1: dout <= 2^(OUT_W-1) - 1 - mag, i.e. the bitwise inverse of the positive value.
  - dout_valid<=v2. The output range is 0 .. 2^OUT_W-1 and is never exceeded.
- Latency: the sample for an en cycle appears with dout_valid=1 three clocks later. At full rate (en held high) there is one sample per clock.
- Stalls: with en=0, dout holds its last value and dout_valid=0 once the pipeline drains. Samples already in flight complete unless clr flushes them.
- Simultaneous events:
  - clr and en together: clr wins.
  - fw_we and en together: the current increment uses the old fw_reg.
  - phase_off is sampled each cycle in stage 1; no handshake.
- Reset mid-operation: immediate return to reset values; no partial samples are emitted afterwards.

Test Plan (ACC_W=32, LUT_AW=8, OUT_W=8):
- Reset values: reset, then release with en=0 -> dout=0x80, dout_valid=0, and both hold for 10 cycles.
- Unit step, fw=0x0100_0000, en held high:
  - dout_valid rises 3 clocks after the first en cycle.
  - dout sequence 0x82, 0x85, ...; address 63 gives 0xFF; address 64 gives 0xFF; address 127 gives 0x82.
  - Address 128 gives 0x7D; address 191 gives 0x00; address 255 gives 0x7D.
  - The period repeats every 256 samples.
- Wrap-around: load acc near 2^32 via fw=0xFFFF_FFFF for 2 cycles, then check that the address sequence continues modulo 256 and dout matches the model (no glitch).
- Phase offset: fw=0x0100_0000, phase_off=64 -> the first sample is 0xFF (cosine start).
  - Change phase_off to 0 mid-run -> samples follow the address shift after the stage-1 latency.
- clr/en/fw_we interplay: clr asserted together with en mid-run -> the in-flight valid samples are dropped, and the next en produces 0x82 after 3 clocks.
  - fw_we with fw=0x0200_0000 during run -> the step size doubles starting one sample later.
- Async reset mid-run: drop rst_n between clock edges -> dout=0x80 and dout_valid=0 immediately; fw_reg returns to FW_RESET.
